score_display_driver: RTL and testbench

- Consumer end of the scoreboard interface. It reads the binary score bus (runs, wickets, innings/game status) and drives a 4-digit multiplexed common-anode 7-segment display.
- Runs are converted to BCD by a sequential shift-add-3 engine, one bit per clock, then time-multiplexed onto the digits alongside a wickets/winner digit.
- Sits between the scoring logic and the board's seg/an pins.

---
 rtl/score_display_driver.sv | 200 ++++++++++++++++++++
 tb/tb_score_display_driver.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_display_driver.sv
// Scoreboard consumer: serial double-dabble BCD of runs plus a muxed 4-digit 7-seg driver.
// Optional LEADING_ZERO_BLANK_EN blanks leading zeros of the run digits.
module score_display_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic       clk_fpga,
    input  logic       reset,
    input  logic [7:0] binaryRuns,
    input  logic [3:0] binaryWickets,
    input  logic       inningOver,
    input  logic       gameOver,
    input  logic       winner,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       bcd_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    state_t            state_q, state_d;
    logic              force_q, force_d;
    logic [7:0]        snap_q, snap_d;
    logic [19:0]       shift_q, shift_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [3:0]        hund_q, hund_d;
    logic [3:0]        tens_q, tens_d;
    logic [3:0]        units_q, units_d;
    logic              valid_q, valid_d;
    logic [3:0]        wk_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [3:0]        an_q, an_d;
    logic [19:0]       dab;
    logic              blank_h, blank_t;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            4'd10:   s = 7'b0001000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Bits [19:8] hold hundreds/tens/units nibbles, [7:0] the binary being shifted out.
    always_comb begin
        state_d  = state_q;
        force_d  = force_q;
        snap_d   = snap_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        hund_d   = hund_q;
        tens_d   = tens_q;
        units_d  = units_q;
        valid_d  = valid_q;
        dab      = shift_q;
        unique case (state_q)
            IDLE: begin
                if (force_q || (binaryRuns != snap_q)) begin
                    snap_d   = binaryRuns;
                    shift_d  = {12'd0, binaryRuns};
                    force_d  = 1'b0;
                    bitcnt_d = 3'd0;
                    state_d  = CONVERT;
                end
            end
            CONVERT: begin
                for (int i = 0; i < 3; i++) begin
                    if (dab[8+4*i +: 4] >= 4'd5)
                        dab[8+4*i +: 4] = dab[8+4*i +: 4] + 4'd3;
                end
                shift_d  = {dab[18:0], 1'b0};
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7)
                    state_d = LOAD;
            end
            LOAD: begin
                hund_d  = shift_q[19:16];
                tens_d  = shift_q[15:12];
                units_d = shift_q[11:8];
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_h = (hund_q == 4'd0);
    assign blank_t = blank_h && (tens_q == 4'd0);
`else
    assign blank_h = 1'b0;
    assign blank_t = 1'b0;
`endif

    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = 4'hF;
        unique case (idx_q)
            2'd0: begin
                an_d = 4'b1110;
                if (valid_q)
                    seg_d = seg7(units_q);
            end
            2'd1: begin
                an_d = 4'b1101;
                if (valid_q && !blank_t)
                    seg_d = seg7(tens_q);
            end
            2'd2: begin
                an_d = 4'b1011;
                if (valid_q && !blank_h)
                    seg_d = seg7(hund_q);
            end
            2'd3: begin
                an_d = 4'b0111;
                if (gameOver)
                    seg_d = winner ? seg7(4'd2) : seg7(4'd1);
                else if (wk_q >= 4'd10)
                    seg_d = seg7(4'd10);
                else
                    seg_d = seg7(wk_q);
                dp_d = !(inningOver && !gameOver);
            end
            default: an_d = 4'hF;
        endcase
    end

    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            force_q  <= 1'b1;
            snap_q   <= 8'd0;
            shift_q  <= 20'd0;
            bitcnt_q <= 3'd0;
            hund_q   <= 4'd0;
            tens_q   <= 4'd0;
            units_q  <= 4'd0;
            valid_q  <= 1'b0;
            wk_q     <= 4'd0;
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
            an_q     <= 4'hF;
        end else begin
            state_q  <= state_d;
            force_q  <= force_d;
            snap_q   <= snap_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            hund_q   <= hund_d;
            tens_q   <= tens_d;
            units_q  <= units_d;
            valid_q  <= valid_d;
            wk_q     <= binaryWickets;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign bcd_valid = valid_q;

endmodule

// File: tb/tb_score_display_driver.sv
// Scoreboard bench for score_display_driver with a short refresh period.
// Expected display slots and BCD triples are queued as stimulus is driven.
module tb_score_display_driver;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] BL = 7'b1111111;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } disp_t;

    typedef struct packed {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
    } bcd_t;

    logic       clk_fpga;
    logic       reset;
    logic [7:0] binaryRuns;
    logic [3:0] binaryWickets;
    logic       inningOver;
    logic       gameOver;
    logic       winner;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       bcd_valid;

    int    ntests = 0;
    int    nfail  = 0;
    disp_t sb[$];
    bcd_t  bq[$];
    disp_t e;
    bcd_t  b;
    bit    ok;

    score_display_driver #(
        .REFRESH_DIV(4),
        .CNT_W(2)
    ) dut (
        .clk_fpga(clk_fpga),
        .reset(reset),
        .binaryRuns(binaryRuns),
        .binaryWickets(binaryWickets),
        .inningOver(inningOver),
        .gameOver(gameOver),
        .winner(winner),
        .seg(seg),
        .dp(dp),
        .an(an),
        .bcd_valid(bcd_valid)
    );

    initial begin
        clk_fpga = 1'b0;
        forever #5 clk_fpga = ~clk_fpga;
    end

    task automatic tick();
        @(posedge clk_fpga);
        #1;
    endtask

    task automatic wait_an(input logic [3:0] want, output bit found);
        found = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (an === want) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        binaryRuns = 8'd0;
        binaryWickets = 4'd0;
        inningOver = 1'b0;
        gameOver = 1'b0;
        winner = 1'b0;
        #1 reset = 1'b1;
        #1;
        ntests++;
        if (seg !== BL || an !== 4'hF || dp !== 1'b1 || bcd_valid !== 1'b0) begin
            nfail++;
            $display("FAIL reset_vals: seg=%b an=%b dp=%b v=%b, expected 1111111 1111 1 0",
                     seg, an, dp, bcd_valid);
        end
        tick();
        reset = 1'b0;
        ntests++;
        if (an !== 4'hF) begin
            nfail++;
            $display("FAIL an_first_cycle: an=%b, expected 1111", an);
        end
        tick();
        ntests++;
        if (an !== 4'b1110 || seg !== BL || bcd_valid !== 1'b0) begin
            nfail++;
            $display("FAIL edge1: an=%b seg=%b v=%b, expected 1110 1111111 0",
                     an, seg, bcd_valid);
        end
        for (int k = 2; k <= 10; k++) begin
            tick();
            if (k == 9) begin
                ntests++;
                if (bcd_valid !== 1'b0) begin
                    nfail++;
                    $display("FAIL valid_edge9: v=%b, expected 0", bcd_valid);
                end
            end
            if (k == 10) begin
                ntests++;
                if (bcd_valid !== 1'b1) begin
                    nfail++;
                    $display("FAIL valid_edge10: v=%b, expected 1", bcd_valid);
                end
            end
        end
        sb.push_back('{4'b1110, S0, 1'b1});
`ifdef LEADING_ZERO_BLANK_EN
        sb.push_back('{4'b1101, BL, 1'b1});
        sb.push_back('{4'b1011, BL, 1'b1});
`else
        sb.push_back('{4'b1101, S0, 1'b1});
        sb.push_back('{4'b1011, S0, 1'b1});
`endif
        sb.push_back('{4'b0111, S0, 1'b1});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_an(e.an, ok);
            ntests++;
            if (!ok || seg !== e.seg || dp !== e.dp) begin
                nfail++;
                $display("FAIL reset_scan an=%b: seg=%b dp=%b found=%0d, expected seg=%b dp=%b",
                         e.an, seg, dp, ok, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_refresh_255();
        logic [3:0] prev;
        binaryRuns = 8'd255;
        binaryWickets = 4'd3;
        for (int i = 0; i < 12; i++) tick();
        ok = 1'b0;
        for (int i = 0; i < 24; i++) begin
            prev = an;
            tick();
            if (an === 4'b1101 && prev !== 4'b1101) begin
                ok = 1'b1;
                break;
            end
        end
        ntests++;
        if (!ok) begin
            nfail++;
            $display("FAIL refresh_sync: an=%b, expected entry to 1101", an);
        end
        sb.push_back('{4'b1101, S5, 1'b1});
        sb.push_back('{4'b1011, S2, 1'b1});
        sb.push_back('{4'b0111, S3, 1'b1});
        sb.push_back('{4'b1110, S5, 1'b1});
        e = sb.pop_front();
        ntests++;
        if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
            nfail++;
            $display("FAIL refresh_slot: an=%b seg=%b dp=%b, expected %b %b %b",
                     an, seg, dp, e.an, e.seg, e.dp);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i < 4; i++) tick();
            ntests++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
                nfail++;
                $display("FAIL refresh_slot: an=%b seg=%b dp=%b, expected %b %b %b",
                         an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_midconv_change();
        binaryRuns = 8'd98;
        for (int i = 0; i < 12; i++) tick();
        binaryRuns = 8'd99;
        bq.push_back('{4'd0, 4'd9, 4'd9});
        for (int i = 0; i < 3; i++) tick();
        binaryRuns = 8'd100;
        bq.push_back('{4'd1, 4'd0, 4'd0});
        for (int i = 0; i < 7; i++) tick();
        b = bq.pop_front();
        ntests++;
        if ({dut.hund_q, dut.tens_q, dut.units_q} !== b) begin
            nfail++;
            $display("FAIL first_load: bcd=%h, expected %h",
                     {dut.hund_q, dut.tens_q, dut.units_q}, b);
        end
        for (int i = 0; i < 10; i++) tick();
        b = bq.pop_front();
        ntests++;
        if ({dut.hund_q, dut.tens_q, dut.units_q} !== b || bcd_valid !== 1'b1) begin
            nfail++;
            $display("FAIL second_load: bcd=%h v=%b, expected %h 1",
                     {dut.hund_q, dut.tens_q, dut.units_q}, bcd_valid, b);
        end
        sb.push_back('{4'b1110, S0, 1'b1});
        sb.push_back('{4'b1101, S0, 1'b1});
        sb.push_back('{4'b1011, S1, 1'b1});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_an(e.an, ok);
            ntests++;
            if (!ok || seg !== e.seg || dp !== e.dp) begin
                nfail++;
                $display("FAIL scan100 an=%b: seg=%b dp=%b found=%0d, expected seg=%b dp=%b",
                         e.an, seg, dp, ok, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_status();
        for (int s = 0; s < 4; s++) begin
            unique case (s)
                0: begin
                    binaryWickets = 4'd10; inningOver = 1'b1; gameOver = 1'b0;
                    sb.push_back('{4'b0111, SA, 1'b0});
                end
                1: begin
                    gameOver = 1'b1; winner = 1'b1;
                    sb.push_back('{4'b0111, S2, 1'b1});
                end
                2: begin
                    winner = 1'b0;
                    sb.push_back('{4'b0111, S1, 1'b1});
                end
                default: begin
                    gameOver = 1'b0; inningOver = 1'b0; binaryWickets = 4'd7;
                    sb.push_back('{4'b0111, S7, 1'b1});
                end
            endcase
            tick();
            tick();
            e = sb.pop_front();
            wait_an(e.an, ok);
            ntests++;
            if (!ok || seg !== e.seg || dp !== e.dp) begin
                nfail++;
                $display("FAIL status_%0d: seg=%b dp=%b found=%0d, expected seg=%b dp=%b",
                         s, seg, dp, ok, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_small_runs();
        for (int r = 0; r < 2; r++) begin
            binaryRuns = (r == 0) ? 8'd7 : 8'd40;
`ifdef LEADING_ZERO_BLANK_EN
            sb.push_back('{4'b1110, (r == 0) ? S7 : S0, 1'b1});
            sb.push_back('{4'b1101, (r == 0) ? BL : S4, 1'b1});
            sb.push_back('{4'b1011, BL, 1'b1});
`else
            sb.push_back('{4'b1110, (r == 0) ? S7 : S0, 1'b1});
            sb.push_back('{4'b1101, (r == 0) ? S0 : S4, 1'b1});
            sb.push_back('{4'b1011, S0, 1'b1});
`endif
            for (int i = 0; i < 12; i++) tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                wait_an(e.an, ok);
                ntests++;
                if (!ok || seg !== e.seg || dp !== e.dp) begin
                    nfail++;
                    $display("FAIL small_runs_%0d an=%b: seg=%b found=%0d, expected seg=%b",
                             r, e.an, seg, ok, e.seg);
                end
            end
        end
    endtask

    task automatic test_reset_midconv();
        binaryRuns = 8'd137;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        #1;
        ntests++;
        if (seg !== BL || an !== 4'hF || dp !== 1'b1 || bcd_valid !== 1'b0) begin
            nfail++;
            $display("FAIL async_reset: seg=%b an=%b dp=%b v=%b, expected 1111111 1111 1 0",
                     seg, an, dp, bcd_valid);
        end
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 9) begin
                ntests++;
                if (bcd_valid !== 1'b0) begin
                    nfail++;
                    $display("FAIL rst_valid_edge9: v=%b, expected 0", bcd_valid);
                end
            end
        end
        ntests++;
        if (bcd_valid !== 1'b1) begin
            nfail++;
            $display("FAIL rst_valid_edge10: v=%b, expected 1", bcd_valid);
        end
        sb.push_back('{4'b1110, S7, 1'b1});
        sb.push_back('{4'b1101, S3, 1'b1});
        sb.push_back('{4'b1011, S1, 1'b1});
        sb.push_back('{4'b0111, S7, 1'b1});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_an(e.an, ok);
            ntests++;
            if (!ok || seg !== e.seg || dp !== e.dp) begin
                nfail++;
                $display("FAIL scan137 an=%b: seg=%b dp=%b found=%0d, expected seg=%b dp=%b",
                         e.an, seg, dp, ok, e.seg, e.dp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_refresh_255();
        test_midconv_change();
        test_status();
        test_small_runs();
        test_reset_midconv();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
